lfsr_sync_checker: RTL and testbench
====================================

Name: lfsr_sync_checker

Overview:
- Receive-side counterpart of the LFSR generator. Samples the generator's parallel output stream and acquires sync by predicting each next state from the previous one.
- Once locked, counts sequence errors and measures the sequence period.
- Runs in the fast clock domain; the generator's slow-clock updates arrive as i_valid strobes.
- Drives the lock, error and period status for display and test logic.

Parameters:
- WIDTH, 4: LFSR state width, in bits.
- TAPS, 4'b1100: feedback tap mask. Bit i set means state bit i is XORed into the feedback.
- LOCK_COUNT, 4: consecutive correct predictions needed to declare lock.
- MISS_LIMIT, 3: consecutive mispredictions in LOCKED that drop lock.
- CW, 16: width of the error counter and of the period counter.

Ports:
- clock_10Mhz  in  1  sole clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- i_valid  in  1  one-cycle strobe; i_data is sampled only when high
- i_data  in  WIDTH  LFSR state word from the generator
- i_clear  in  1  synchronous clear of o_err_count
- o_locked  out  1  high while the FSM is in LOCKED
- o_error  out  1  one-cycle pulse per misprediction while LOCKED
- o_err_count  out  CW  saturating error total
- o_period  out  CW  last measured sequence period, in samples
- o_period_valid  out  1  one-cycle pulse when o_period updates

Behaviour:
- Next-state function: next(s) = {s[WIDTH-2:0], ^(s & TAPS)}.
  - With defaults this is the 15-state maximal sequence.
  - All-zero is the lockup state: i_data == 0 never counts as a match.
- Registers: prev (WIDTH), have_prev, match_cnt, miss_cnt, ref (WIDTH), per_cnt (CW).
- Sample definition: on i_valid, pred = next(prev); match = have_prev && i_data == pred && i_data != 0.
- All outputs are registered. They reflect a sample one clock after the i_valid cycle. Nothing changes while i_valid is low.
- FSM states: SEARCH (reset state) and LOCKED.
- SEARCH, on each sample:
  - prev <= i_data and have_prev <= 1.
  - On match: match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED, clear match_cnt and miss_cnt, set ref <= i_data and per_cnt <= 0.
  - On no match: match_cnt <= 0.
- LOCKED, match: prev <= i_data; miss_cnt <= 0.
- LOCKED, mismatch:
  - Flywheel: prev <= pred, so one corrupted word does not cascade.
  - o_error pulses; o_err_count increments.
  - miss_cnt++. When miss_cnt reaches MISS_LIMIT, go to SEARCH, clear match_cnt and have_prev, and drop o_locked.
- Period measurement, in LOCKED, on each sample:
  - per_cnt++.
  - If match and i_data == ref: o_period <= per_cnt+1, pulse o_period_valid, per_cnt <= 0.
  - If per_cnt is saturated at all-ones, hold it and suppress the pulse.
- Error counter:
  - Saturates at all-ones; never wraps.
  - i_clear and an increment in the same cycle give a result of 1.
  - i_clear alone gives 0.
  - i_clear does not affect the FSM or the period logic.
- Leaving LOCKED: o_period holds its last value; o_period_valid stays low.
- Reset: all registers and outputs go to 0, FSM to SEARCH. Reset mid-lock drops o_locked immediately (asynchronous).

Decomposition:
- Package lfsr_pkg holds:
  - the default TAPS and WIDTH constants;
  - the lfsr_next(state, taps) function;
  - the FSM state enum {SEARCH, LOCKED}.
- One combinational sub-module, lfsr_predict (inputs state and taps, output next state). It is shared with the generator so both ends use the identical polynomial.

Test Plan:
- Lock acquisition:
  - Stimulus: i_valid every 8 clocks, sequence 0001,0010,0100,1001,0011,...
  - Response: o_locked rises 1 clock after the 5th strobe (0011); ref = 0011.
- Period measurement:
  - Stimulus: keep feeding the sequence after lock.
  - Response: o_period_valid pulses when 0011 recurs 15 samples later; o_period = 15; repeats every 15 samples.
- Single error:
  - Stimulus: while locked, replace one word with 0000.
  - Response: one o_error pulse, o_err_count = 1, o_locked stays high, the next correct word matches (flywheel).
- Loss of lock:
  - Stimulus: while locked, send 3 consecutive wrong words.
  - Response: o_err_count += 3, o_locked falls 1 clock after the 3rd. Correct data re-locks after 1+LOCK_COUNT samples.
- Clear and saturation:
  - Stimulus: CW = 4, 20 errors.
  - Response: o_err_count = 15 and holds. i_clear together with an error gives 1; i_clear alone gives 0.
- Reset mid-lock:
  - Stimulus: assert reset low for 2 clocks while locked.
  - Response: all outputs 0 immediately. The first sample after release only loads prev (no match counted).

Source files
------------

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR generator / sync checker pair:
//   - default state width and feedback tap mask
//   - lfsr_next(): next-state function used by both ends of the link
//   - sync_state_e: receive-side synchronisation FSM states
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int                    LFSR_WIDTH = 4;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 4'b1100;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } sync_state_e;

    // Shift left, feed the parity of the tapped bits into bit 0. Operates on a
    // 32-bit container so any width up to 32 can use it: callers zero-extend
    // state and taps, then keep the low WIDTH bits of the result (the bit that
    // shifts out of position WIDTH-1 is discarded by that truncation).
    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] taps);
        return {state[30:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// -----------------------------------------------------------------------------
// lfsr_predict
// Combinational next-state predictor, shared with the generator so both ends
// evaluate exactly the same polynomial.
// Ports:
//   state      in  WIDTH  current LFSR state
//   taps       in  WIDTH  feedback tap mask (bit i set: state[i] feeds back)
//   next_state out WIDTH  state after one LFSR step
// -----------------------------------------------------------------------------
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_WIDTH
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next_state
);

    assign next_state = WIDTH'(lfsr_next(32'(state), 32'(taps)));

endmodule

// File: rtl/lfsr_sync_checker.sv
// -----------------------------------------------------------------------------
// lfsr_sync_checker
// Receive-side checker for the LFSR generator. Acquires sync by predicting each
// sampled word from the previous one, then counts sequence errors and measures
// the sequence period while locked.
// Ports:
//   clock_10Mhz    in   1      sole clock, rising edge
//   reset          in   1      asynchronous, active-low
//   i_valid        in   1      one-cycle strobe qualifying i_data
//   i_data         in   WIDTH  LFSR state word from the generator
//   i_clear        in   1      synchronous clear of o_err_count
//   o_locked       out  1      high while locked
//   o_error        out  1      one-cycle pulse per misprediction while locked
//   o_err_count    out  CW     saturating error total
//   o_period       out  CW     last measured sequence period, in samples
//   o_period_valid out  1      one-cycle pulse when o_period updates
// -----------------------------------------------------------------------------
module lfsr_sync_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(LFSR_TAPS),
    parameter int               LOCK_COUNT = 4,
    parameter int               MISS_LIMIT = 3,
    parameter int               CW         = 16
) (
    input  logic             clock_10Mhz,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_error,
    output logic [CW-1:0]    o_err_count,
    output logic [CW-1:0]    o_period,
    output logic             o_period_valid
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int MS_W = $clog2(MISS_LIMIT + 1);

    // Registered state
    sync_state_e      state_q;
    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q;
    logic [MC_W-1:0]  match_cnt_q;
    logic [MS_W-1:0]  miss_cnt_q;
    logic [WIDTH-1:0] ref_q;
    logic [CW-1:0]    per_cnt_q;

    // Next-state values
    sync_state_e      state_d;
    logic [WIDTH-1:0] prev_d;
    logic             have_prev_d;
    logic [MC_W-1:0]  match_cnt_d;
    logic [MS_W-1:0]  miss_cnt_d;
    logic [WIDTH-1:0] ref_d;
    logic [CW-1:0]    per_cnt_d;
    logic [CW-1:0]    period_d;
    logic             period_valid_d;
    logic             error_d;
    logic [CW-1:0]    err_cnt_d;
    logic             err_inc;

    // Sample qualification
    logic [WIDTH-1:0] pred;
    logic             match;
    logic             per_sat;
    logic [CW-1:0]    per_inc;
    logic [MC_W-1:0]  match_cnt_inc;
    logic [MS_W-1:0]  miss_cnt_inc;

    lfsr_predict #(
        .WIDTH (WIDTH)
    ) u_predict (
        .state      (prev_q),
        .taps       (TAPS),
        .next_state (pred)
    );

    // All-zero is the lockup state, so it never counts as a good word even if
    // the predictor were to produce it.
    assign match         = have_prev_q && (i_data == pred) && (i_data != '0);
    assign per_sat       = &per_cnt_q;
    assign per_inc       = per_cnt_q + 1'b1;
    assign match_cnt_inc = match_cnt_q + 1'b1;
    assign miss_cnt_inc  = miss_cnt_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // left one unassigned would infer a latch.
        state_d        = state_q;
        prev_d         = prev_q;
        have_prev_d    = have_prev_q;
        match_cnt_d    = match_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        ref_d          = ref_q;
        per_cnt_d      = per_cnt_q;
        period_d       = o_period;
        period_valid_d = 1'b0;
        error_d        = 1'b0;
        err_inc        = 1'b0;

        if (i_valid) begin
            case (state_q)
                SEARCH: begin
                    prev_d      = i_data;
                    have_prev_d = 1'b1;
                    if (match) begin
                        if (match_cnt_inc == MC_W'(LOCK_COUNT)) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            ref_d       = i_data;
                            per_cnt_d   = '0;
                        end else begin
                            match_cnt_d = match_cnt_inc;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end

                LOCKED: begin
                    // A saturated period counter means the reference word was
                    // never seen within 2^CW-1 samples: freeze it and report
                    // nothing rather than publish a wrapped value.
                    if (!per_sat) begin
                        per_cnt_d = per_inc;
                    end

                    if (match) begin
                        prev_d     = i_data;
                        miss_cnt_d = '0;
                        if ((i_data == ref_q) && !per_sat) begin
                            period_d       = per_inc;
                            period_valid_d = 1'b1;
                            per_cnt_d      = '0;
                        end
                    end else begin
                        // Flywheel on the prediction so one corrupted word
                        // does not make the following good word mismatch too.
                        prev_d  = pred;
                        error_d = 1'b1;
                        err_inc = 1'b1;
                        if (miss_cnt_inc == MS_W'(MISS_LIMIT)) begin
                            state_d     = SEARCH;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            have_prev_d = 1'b0;
                        end else begin
                            miss_cnt_d = miss_cnt_inc;
                        end
                    end
                end

                default: state_d = SEARCH;
            endcase
        end

        // Clear wins over the old total but not over a same-cycle error.
        if (i_clear) begin
            err_cnt_d = err_inc ? CW'(1) : '0;
        end else if (err_inc && !(&o_err_count)) begin
            err_cnt_d = o_err_count + 1'b1;
        end else begin
            err_cnt_d = o_err_count;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_10Mhz or negedge reset) begin
        if (!reset) begin
            state_q        <= SEARCH;
            prev_q         <= '0;
            have_prev_q    <= 1'b0;
            match_cnt_q    <= '0;
            miss_cnt_q     <= '0;
            ref_q          <= '0;
            per_cnt_q      <= '0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_error        <= 1'b0;
            o_err_count    <= '0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            have_prev_q    <= have_prev_d;
            match_cnt_q    <= match_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            ref_q          <= ref_d;
            per_cnt_q      <= per_cnt_d;
            o_period       <= period_d;
            o_period_valid <= period_valid_d;
            o_error        <= error_d;
            o_err_count    <= err_cnt_d;
        end
    end

    assign o_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_lfsr_sync_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_sync_checker
// Drives two checker instances (CW=16 and CW=4) with the same stream of LFSR
// words, randomly corrupted, and compares both against a behavioural model
// built from the sequence-tracking rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_lfsr_sync_checker;

    localparam int TAP_MASK = 12;   // 4'b1100
    localparam int LOCK_N   = 4;
    localparam int MISS_N   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_clear = 1'b0;
    logic [3:0]  i_data = '0;

    logic        a_locked, a_error, a_pv;
    logic [15:0] a_err, a_period;
    logic        b_locked, b_error, b_pv;
    logic [3:0]  b_err, b_period;

    always #5 clk = ~clk;

    lfsr_sync_checker u_dut_a (
        .clock_10Mhz    (clk),
        .reset          (rst_n),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_clear        (i_clear),
        .o_locked       (a_locked),
        .o_error        (a_error),
        .o_err_count    (a_err),
        .o_period       (a_period),
        .o_period_valid (a_pv)
    );

    lfsr_sync_checker #(.CW(4)) u_dut_b (
        .clock_10Mhz    (clk),
        .reset          (rst_n),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_clear        (i_clear),
        .o_locked       (b_locked),
        .o_error        (b_error),
        .o_err_count    (b_err),
        .o_period       (b_period),
        .o_period_valid (b_pv)
    );

    // ---------------------------------------------------------------- checking
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------- model
    // Shared sequence tracking, plus per-instance counters (index 0: CW=16,
    // index 1: CW=4) since only the counter widths differ.
    int m_prev, m_mcnt, m_miss, m_ref;
    bit m_have, m_locked, m_error;
    int m_per[2], m_period[2], m_err[2];
    bit m_pv[2];
    int cmax[2] = '{65535, 15};

    function automatic int nxt(input int s);
        return ((s << 1) & 15) | ($countones(s & TAP_MASK) & 1);
    endfunction

    task automatic model_reset();
        m_prev = 0; m_mcnt = 0; m_miss = 0; m_ref = 0;
        m_have = 0; m_locked = 0; m_error = 0;
        for (int k = 0; k < 2; k++) begin
            m_per[k] = 0; m_period[k] = 0; m_err[k] = 0; m_pv[k] = 0;
        end
    endtask

    task automatic model_sample(input int d, input bit clr);
        int  pred;
        bit  good;
        pred    = nxt(m_prev);
        good    = m_have && (d == pred) && (d != 0);
        m_error = 0;
        m_pv[0] = 0;
        m_pv[1] = 0;
        if (!m_locked) begin
            m_prev = d;
            m_have = 1;
            if (good) begin
                m_mcnt++;
                if (m_mcnt == LOCK_N) begin
                    m_locked = 1; m_mcnt = 0; m_miss = 0; m_ref = d;
                    m_per[0] = 0; m_per[1] = 0;
                end
            end else begin
                m_mcnt = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_per[k] != cmax[k]) begin
                    // samples since the last reference word, counting this one
                    m_per[k] = m_per[k] + 1;
                    if (good && d == m_ref) begin
                        m_period[k] = m_per[k];
                        m_pv[k]     = 1;
                        m_per[k]    = 0;
                    end
                end
            end
            if (good) begin
                m_prev = d;
                m_miss = 0;
            end else begin
                m_prev  = pred;
                m_error = 1;
                m_miss++;
                if (m_miss == MISS_N) begin
                    m_locked = 0; m_mcnt = 0; m_have = 0; m_miss = 0;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (clr)                           m_err[k] = m_error ? 1 : 0;
            else if (m_error && m_err[k] < cmax[k]) m_err[k] = m_err[k] + 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".a_locked"}, 32'(a_locked), 32'(m_locked));
        check({tag, ".a_error"},  32'(a_error),  32'(m_error));
        check({tag, ".a_err"},    32'(a_err),    32'(m_err[0]));
        check({tag, ".a_period"}, 32'(a_period), 32'(m_period[0]));
        check({tag, ".a_pv"},     32'(a_pv),     32'(m_pv[0]));
        check({tag, ".b_locked"}, 32'(b_locked), 32'(m_locked));
        check({tag, ".b_error"},  32'(b_error),  32'(m_error));
        check({tag, ".b_err"},    32'(b_err),    32'(m_err[1]));
        check({tag, ".b_period"}, 32'(b_period), 32'(m_period[1]));
        check({tag, ".b_pv"},     32'(b_pv),     32'(m_pv[1]));
    endtask

    // --------------------------------------------------------------- stimulus
    int g;          // generator state: next word the source will send
    int pulse_cnt;

    task automatic strobe(input int d, input bit clr, input int gap, input string tag);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 4'(d);
        i_clear = clr;
        model_sample(d, clr);
        @(negedge clk);
        i_valid = 1'b0;
        i_clear = 1'b0;
        check_outputs(tag);
        if (a_pv) pulse_cnt++;
        if (gap > 0) begin
            repeat (gap) @(negedge clk);
            m_error = 0; m_pv[0] = 0; m_pv[1] = 0;
            check_outputs({tag, ".idle"});
        end
    endtask

    task automatic feed_good(input int gap, input bit clr);
        strobe(g, clr, gap, "good");
        g = nxt(g);
    endtask

    task automatic feed_bad(input int d, input bit clr);
        strobe(d, clr, 1, "bad");
        g = nxt(g);
    endtask

    task automatic clear_only();
        @(negedge clk);
        i_clear = 1'b1;
        m_err[0] = 0; m_err[1] = 0;
        m_error = 0; m_pv[0] = 0; m_pv[1] = 0;
        @(negedge clk);
        i_clear = 1'b0;
        check_outputs("clear");
    endtask

    task automatic ensure_locked();
        for (int i = 0; i < 20 && !m_locked; i++) feed_good(1, 1'b0);
        feed_good(1, 1'b0);
        check("prelock", 32'(a_locked), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        pulse_cnt = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Lock acquisition: 0001,0010,0100,1001,0011 at one strobe per 8 clocks
        g = 1;
        for (int i = 0; i < 5; i++) begin
            feed_good(7, 1'b0);
            if (i == 3) check("lock_early", 32'(a_locked), 32'd0);
        end
        check("lock_at_5th", 32'(a_locked), 32'd1);

        // Period measurement: 0011 recurs every 15 samples
        pulse_cnt = 0;
        for (int i = 0; i < 30; i++) feed_good($urandom_range(0, 3), 1'b0);
        check("period_pulses", 32'(pulse_cnt), 32'd2);
        check("period_value", 32'(a_period), 32'd15);

        // Single corrupted word: flywheel keeps lock, next good word matches
        feed_bad(0, 1'b0);
        check("single_err_cnt", 32'(a_err), 32'd1);
        check("single_err_lock", 32'(a_locked), 32'd1);
        feed_good(1, 1'b0);
        check("flywheel_match", 32'(a_error), 32'd0);

        // Randomised traffic: good words, corrupted words, bursts, clears
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                feed_good($urandom_range(0, 2), 1'b0);
            end else if (r < 84) begin
                feed_bad(g ^ $urandom_range(1, 15), 1'b0);
            end else if (r < 90) begin
                for (int j = 0; j < 3; j++) feed_bad($urandom_range(0, 15), 1'b0);
            end else if (r < 95) begin
                feed_good(1, 1'b1);
            end else begin
                clear_only();
            end
        end

        // Loss of lock after three consecutive wrong words, then re-lock
        ensure_locked();
        clear_only();
        feed_bad(0, 1'b0);
        feed_bad(0, 1'b0);
        check("miss2_still_locked", 32'(a_locked), 32'd1);
        feed_bad(0, 1'b0);
        check("miss3_err_cnt", 32'(a_err), 32'd3);
        check("miss3_unlocked", 32'(a_locked), 32'd0);
        for (int i = 0; i < 5; i++) begin
            feed_good(1, 1'b0);
            if (i == 3) check("relock_early", 32'(a_locked), 32'd0);
        end
        check("relock", 32'(a_locked), 32'd1);

        // Saturation on the CW=4 instance, then clear behaviour
        ensure_locked();
        clear_only();
        for (int i = 0; i < 20; i++) begin
            feed_bad(0, 1'b0);
            feed_good(1, 1'b0);
        end
        check("sat_b", 32'(b_err), 32'd15);
        check("sat_a", 32'(a_err), 32'd20);
        feed_bad(0, 1'b1);
        check("clr_with_err_a", 32'(a_err), 32'd1);
        check("clr_with_err_b", 32'(b_err), 32'd1);
        clear_only();
        check("clr_alone_b", 32'(b_err), 32'd0);

        // Reset while locked: outputs drop at once, first sample only loads prev
        ensure_locked();
        feed_bad(0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_locked", 32'(a_locked), 32'd0);
        check("rst_err",    32'(a_err),    32'd0);
        check("rst_period", 32'(a_period), 32'd0);
        check("rst_b_err",  32'(b_err),    32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs("post_reset");
        for (int i = 0; i < 5; i++) begin
            feed_good(1, 1'b0);
            if (i == 3) check("rst_relock_early", 32'(a_locked), 32'd0);
        end
        check("rst_relock", 32'(a_locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
